// File: rtl/bfly_feeder_if.sv
// Stream bundle between the sample source, the butterfly feeder and the butterfly stage.
// master: upstream side (drives input vectors, observes operands); slave: the feeder.
interface bfly_feeder_if #(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 16
);
    logic                                  din_valid;
    logic                                  frame_start;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] din_re;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] din_im;

    logic                                  bfly_valid;
    logic                                  frame_done;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] bfly_din_re;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] bfly_din_im;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] shift_data_re;
    logic signed [NUM_PAIR-1:0][WIDTH-1:0] shift_data_im;

    modport master (
        output din_valid, frame_start, din_re, din_im,
        input  bfly_valid, frame_done, bfly_din_re, bfly_din_im,
               shift_data_re, shift_data_im
    );

    modport slave (
        input  din_valid, frame_start, din_re, din_im,
        output bfly_valid, frame_done, bfly_din_re, bfly_din_im,
               shift_data_re, shift_data_im
    );
endinterface

// File: rtl/bfly_feeder.sv
// Radix-2 butterfly input sequencer: buffers the first half-frame, then pairs it with the second.
// Optional sticky mid-frame-abort flag frame_err is enabled by defining BFLY_FEEDER_ERR_EN.
module bfly_feeder #(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 16,
    parameter int DEPTH    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    bfly_feeder_if.slave  bus
`ifdef BFLY_FEEDER_ERR_EN
    ,
    output logic          frame_err
`endif
);

    localparam int            CW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] PAIR = 2'd2;

    typedef logic signed [NUM_PAIR-1:0][WIDTH-1:0] vec_t;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic          pair_en;
    logic          last_pair;

    vec_t mem_re_q [DEPTH];
    vec_t mem_im_q [DEPTH];

    logic bfly_valid_q;
    logic frame_done_q;
    vec_t bfly_din_re_q, bfly_din_im_q;
    vec_t shift_re_q, shift_im_q;

    // A frame_start with data restarts the frame from any state, so it is decoded first.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_addr   = cnt_q;
        pair_en   = 1'b0;
        last_pair = 1'b0;

        if (bus.din_valid) begin
            if (bus.frame_start) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                cnt_d   = CW'(1);
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL: begin
                        wr_en = 1'b1;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = PAIR;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PAIR: begin
                        pair_en = 1'b1;
                        if (cnt_q == LAST) begin
                            last_pair = 1'b1;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    IDLE:    ;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the delay buffer is never read before it is written within a frame, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re_q[wr_addr] <= bus.din_re;
            mem_im_q[wr_addr] <= bus.din_im;
        end
    end

    // Operands only load on a pairing cycle and otherwise hold; the strobes drop back to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bfly_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            bfly_din_re_q <= '0;
            bfly_din_im_q <= '0;
            shift_re_q    <= '0;
            shift_im_q    <= '0;
        end else begin
            bfly_valid_q <= pair_en;
            frame_done_q <= last_pair;
            if (pair_en) begin
                bfly_din_re_q <= bus.din_re;
                bfly_din_im_q <= bus.din_im;
                shift_re_q    <= mem_re_q[cnt_q];
                shift_im_q    <= mem_im_q[cnt_q];
            end
        end
    end

    assign bus.bfly_valid    = bfly_valid_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.bfly_din_re   = bfly_din_re_q;
    assign bus.bfly_din_im   = bfly_din_im_q;
    assign bus.shift_data_re = shift_re_q;
    assign bus.shift_data_im = shift_im_q;

`ifdef BFLY_FEEDER_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (bus.din_valid && bus.frame_start && (state_q != IDLE)) begin
            err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_bfly_feeder.sv
// Directed bench for bfly_feeder: per-cycle expectations go through a scoreboard queue.
module tb_bfly_feeder;

    localparam int W  = 12;
    localparam int NP = 16;
    localparam int D  = 16;
    localparam int VW = NP * W;

    typedef logic signed [NP-1:0][W-1:0] vec_t;

    typedef struct {
        logic v;
        logic d;
        vec_t bre;
        vec_t bim;
        vec_t sre;
        vec_t sim;
    } exp_t;

    logic clk;
    logic rstn;
`ifdef BFLY_FEEDER_ERR_EN
    logic frame_err;
`endif

    bfly_feeder_if #(.WIDTH(W), .NUM_PAIR(NP)) bus ();

    bfly_feeder #(.WIDTH(W), .NUM_PAIR(NP), .DEPTH(D)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus)
`ifdef BFLY_FEEDER_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   nvalid;
    bit   exp_err = 1'b0;
    exp_t sb [$];
    exp_t held;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t lanes(input int base, input int stp);
        vec_t v;
        for (int i = 0; i < NP; i++) v[i] = W'(base + i * stp);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < NP; i++) v[i] = W'($urandom);
        return v;
    endfunction

    function automatic vec_t fre(input int c, input int ofs); return lanes(c * 10 + ofs, 1);       endfunction
    function automatic vec_t fim(input int c, input int ofs); return lanes(c * 10 + 100 + ofs, 1); endfunction
    function automatic vec_t pre(input int k, input int ofs); return lanes(k + 30 + ofs, 0);       endfunction
    function automatic vec_t pim(input int k, input int ofs); return lanes(k + 130 + ofs, 0);      endfunction

    task automatic check_outputs(input exp_t e, input string ctx);
        check({ctx, ".bfly_valid"},    VW'(bus.bfly_valid),    VW'(e.v));
        check({ctx, ".frame_done"},    VW'(bus.frame_done),    VW'(e.d));
        check({ctx, ".bfly_din_re"},   VW'(bus.bfly_din_re),   VW'(e.bre));
        check({ctx, ".bfly_din_im"},   VW'(bus.bfly_din_im),   VW'(e.bim));
        check({ctx, ".shift_data_re"}, VW'(bus.shift_data_re), VW'(e.sre));
        check({ctx, ".shift_data_im"}, VW'(bus.shift_data_im), VW'(e.sim));
`ifdef BFLY_FEEDER_ERR_EN
        check({ctx, ".frame_err"},     VW'(frame_err),         VW'(exp_err));
`endif
    endtask

    // Drive one input cycle; the result is due one clock later and is checked on the falling edge.
    task automatic step(input string ctx, input bit v, input bit fs, input vec_t re, input vec_t im,
                        input bit ev, input bit ed, input vec_t sre, input vec_t sim);
        exp_t e;
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din_re      = re;
        bus.din_im      = im;
        e = held;
        e.v = ev;
        e.d = ed;
        if (ev) begin
            e.bre = re;
            e.bim = im;
            e.sre = sre;
            e.sim = sim;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check_outputs(e, ctx);
        held = e;
        if (bus.bfly_valid) nvalid++;
    endtask

    task automatic gap_step();
        step("gap", 1'b0, 1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_frame(input string ctx, input int ofs, input bit gapped);
        int slot = 0;
        nvalid = 0;
        for (int c = 0; c < D; c++) begin
            if (gapped && (slot % 3 == 2)) begin gap_step(); slot++; end
            step({ctx, ".fill"}, 1'b1, c == 0, fre(c, ofs), fim(c, ofs), 1'b0, 1'b0, '0, '0);
            slot++;
        end
        for (int k = 0; k < D; k++) begin
            if (gapped && (slot % 3 == 2)) begin gap_step(); slot++; end
            step({ctx, ".pair"}, 1'b1, 1'b0, pre(k, ofs), pim(k, ofs), 1'b1, k == D - 1,
                 fre(k, ofs), fim(k, ofs));
            slot++;
        end
        check({ctx, ".valid_count"}, VW'(nvalid), VW'(D));
    endtask

    task automatic reset_expect();
        held = '{v: 1'b0, d: 1'b0, bre: '0, bim: '0, sre: '0, sim: '0};
        exp_err = 1'b0;
    endtask

    initial begin
        rstn            = 1'b0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.din_re      = '0;
        bus.din_im      = '0;
        reset_expect();
        repeat (2) @(negedge clk);
        check_outputs(held, "reset");
        rstn = 1'b1;
        @(negedge clk);

        // Valid data without frame_start is dropped while idle.
        for (int n = 0; n < 10; n++)
            step("idle_noise", 1'b1, 1'b0, rnd_vec(), rnd_vec(), 1'b0, 1'b0, '0, '0);

        run_frame("nominal", 0, 1'b0);
        run_frame("gapped", 0, 1'b1);
        run_frame("b2b_a", 7, 1'b0);
        run_frame("b2b_b", 11, 1'b0);

        // Mid-frame abort at PAIR k=5; the abort vector becomes buf[0] of the new frame.
        for (int c = 0; c < D; c++)
            step("abort.fill", 1'b1, c == 0, fre(c, 0), fim(c, 0), 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++)
            step("abort.pair", 1'b1, 1'b0, pre(k, 0), pim(k, 0), 1'b1, 1'b0, fre(k, 0), fim(k, 0));
        exp_err = 1'b1;
        step("abort.restart", 1'b1, 1'b1, lanes(500, 0), lanes(600, 0), 1'b0, 1'b0, '0, '0);
        for (int c = 1; c < D; c++)
            step("abort.refill", 1'b1, 1'b0, fre(c, 0), fim(c, 0), 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < D; k++)
            step("abort.repair", 1'b1, 1'b0, pre(k, 0), pim(k, 0), 1'b1, k == D - 1,
                 (k == 0) ? lanes(500, 0) : fre(k, 0), (k == 0) ? lanes(600, 0) : fim(k, 0));
        run_frame("after_abort", 5, 1'b0);

        // Reset in the middle of FILL, then a fresh frame.
        for (int c = 0; c < 7; c++)
            step("rst.fill", 1'b1, c == 0, fre(c, 2), fim(c, 2), 1'b0, 1'b0, '0, '0);
        rstn          = 1'b0;
        bus.din_valid = 1'b0;
        reset_expect();
        #1;
        check_outputs(held, "rst.during");
        repeat (2) @(negedge clk);
        check_outputs(held, "rst.hold");
        rstn = 1'b1;
        for (int n = 0; n < 3; n++)
            step("rst.idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        run_frame("fresh", 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
